multi_paddle_controller: RTL

MULTI_PADDLE_CONTROLLER -- requirements
Module: multi_paddle_controller

---
 rtl/multi_paddle_controller_pkg.sv | 34 +++
 rtl/multi_paddle_controller_scan_code_parser.sv | 92 +++++++++
 rtl/multi_paddle_controller.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/multi_paddle_controller_pkg.sv
// Shared definitions for the multi-paddle controller: scan-code parser
// states, PS/2 prefix codes, default key bindings and playfield geometry.
package multi_paddle_controller_pkg;

  // Parser position within a make / break / extended sequence
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } parser_state_t;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;

  // Default bindings for two players, player 0 in the low byte
  localparam logic [15:0] DEF_UP_KEYS   = {8'h44, 8'h1D};
  localparam logic [15:0] DEF_DOWN_KEYS = {8'h4B, 8'h1B};

  localparam int unsigned DEF_SCREEN_HEIGHT = 480;
  localparam int unsigned DEF_PADDLE_LENGTH = 40;
  localparam int unsigned DEF_FRAME_WIDTH   = 10;
  localparam int unsigned DEF_STEP          = 10;
  localparam int unsigned DEF_MAX_STEP      = 30;
  localparam int unsigned DEF_ACCEL_TICKS   = 8;
  localparam int unsigned DEF_COUNT         = 500000;
  localparam int unsigned DEF_TIMEOUT       = 65536;

  // True for the codes that open a multi-byte sequence
  function automatic logic is_prefix(input logic [7:0] c);
    return (c == CODE_BREAK) || (c == CODE_EXT);
  endfunction

endpackage

// File: rtl/multi_paddle_controller_scan_code_parser.sv
// PS/2 scan-code parser: rising-edge accept of code_valid, make/break/extended
// sequencing and a prefix timeout that abandons a half-received sequence.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   code, code_valid  scan code and its level-valid qualifier
//   make_c, brk_c     combinational strobes in the accept cycle of a plain
//                     make code or of the code following an F0 prefix
//   key_code_c        code that the strobes refer to
module scan_code_parser
  import multi_paddle_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code,
  input  logic       code_valid,
  output logic       make_c,
  output logic       brk_c,
  output logic [7:0] key_code_c
);

  localparam int unsigned    TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  parser_state_t   state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            code_valid_q;
  logic            first_q;
  logic            accept_c;

  // first_q masks the cycle right after reset so a level already high is not
  // mistaken for a fresh rising edge
  assign accept_c   = code_valid & ~code_valid_q & ~first_q;
  assign key_code_c = code;

  // State, timeout and edge-detect registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      to_cnt_q     <= '0;
      code_valid_q <= 1'b0;
      first_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      code_valid_q <= code_valid;
      first_q      <= 1'b0;
    end
  end

  // Next state, timeout count and strobes
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    make_c   = 1'b0;
    brk_c    = 1'b0;

    if (state_q != IDLE) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    if (accept_c) begin
      to_cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (code == CODE_BREAK) begin
            state_d = BRK;
          end else if (code == CODE_EXT) begin
            state_d = EXT;
          end else begin
            make_c = !is_prefix(code);
          end
        end
        BRK: begin
          brk_c   = 1'b1;
          state_d = IDLE;
        end
        EXT: begin
          state_d = (code == CODE_BREAK) ? EXT_BRK : IDLE;
        end
        EXT_BRK: begin
          state_d = IDLE;
        end
      endcase
    end else if ((state_q != IDLE) && (to_cnt_q == TO_LAST)) begin
      state_d  = IDLE;
      to_cnt_d = '0;
    end
  end

endmodule

// File: rtl/multi_paddle_controller.sv
// Keyboard-driven paddle controller for up to four players. Scan codes are
// decoded into per-player up/down held flags; on every motion tick each
// player with exactly one direction held moves by STEP, or by MAX_STEP once
// the direction has been held for ACCEL_TICKS consecutive moves.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   code         scan code from the PS/2 receiver
//   code_valid   level qualifier, accepted on its rising edge
//   freeze       holds positions while high
//   center       one-cycle strobe returning all paddles to the start position
//   paddle_pos   per-player paddle top, player i at [POS_W*i +: POS_W]
//   key_held     per-player held flags, bit 2i up, bit 2i+1 down
//   tick         one-cycle motion pulse every COUNT+1 cycles
module multi_paddle_controller
  import multi_paddle_controller_pkg::*;
#(
  parameter int unsigned              N_PLAYERS     = 2,
  parameter logic [8*N_PLAYERS-1:0]   UP_KEYS       = DEF_UP_KEYS,
  parameter logic [8*N_PLAYERS-1:0]   DOWN_KEYS     = DEF_DOWN_KEYS,
  parameter int unsigned              SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int unsigned              PADDLE_LENGTH = DEF_PADDLE_LENGTH,
  parameter int unsigned              FRAME_WIDTH   = DEF_FRAME_WIDTH,
  parameter int unsigned              STEP          = DEF_STEP,
  parameter int unsigned              MAX_STEP      = DEF_MAX_STEP,
  parameter int unsigned              ACCEL_TICKS   = DEF_ACCEL_TICKS,
  parameter int unsigned              COUNT         = DEF_COUNT,
  parameter int unsigned              TIMEOUT       = DEF_TIMEOUT,
  localparam int unsigned             POS_W         = $clog2(SCREEN_HEIGHT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   code,
  input  logic                         code_valid,
  input  logic                         freeze,
  input  logic                         center,
  output logic [N_PLAYERS*POS_W-1:0]   paddle_pos,
  output logic [2*N_PLAYERS-1:0]       key_held,
  output logic                         tick
);

  localparam int unsigned BOTTOM_POS = SCREEN_HEIGHT - PADDLE_LENGTH - FRAME_WIDTH;
  localparam int unsigned START_POS  = (SCREEN_HEIGHT - PADDLE_LENGTH) / 2;
  localparam int unsigned SUM_W      = POS_W + 1;
  localparam int unsigned CNT_W      = (COUNT > 0) ? $clog2(COUNT + 1) : 1;
  localparam int unsigned HOLD_W     = (ACCEL_TICKS > 0) ? $clog2(ACCEL_TICKS + 1) : 1;

  localparam logic [POS_W-1:0]        START_P    = POS_W'(START_POS);
  localparam logic signed [SUM_W-1:0] BOTTOM_S   = SUM_W'(BOTTOM_POS);
  localparam logic signed [SUM_W-1:0] FRAME_S    = SUM_W'(FRAME_WIDTH);
  localparam logic signed [SUM_W-1:0] STEP_S     = SUM_W'(STEP);
  localparam logic signed [SUM_W-1:0] MAX_STEP_S = SUM_W'(MAX_STEP);
  localparam logic [HOLD_W-1:0]       ACCEL_H    = HOLD_W'(ACCEL_TICKS);
  localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(COUNT);

  logic                             make_c, brk_c;
  logic [7:0]                       key_code_c;
  logic [2*N_PLAYERS-1:0]           key_held_d;
  logic [CNT_W-1:0]                 tick_cnt_q, tick_cnt_d;
  logic [N_PLAYERS-1:0][POS_W-1:0]  pos_q, pos_d;
  logic [N_PLAYERS-1:0][HOLD_W-1:0] hold_q, hold_d;
  logic [N_PLAYERS-1:0]             dir_q, dir_d;   // 1 = last move was down

  scan_code_parser #(
    .TIMEOUT (TIMEOUT)
  ) u_parser (
    .clk        (clk),
    .rst        (rst),
    .code       (code),
    .code_valid (code_valid),
    .make_c     (make_c),
    .brk_c      (brk_c),
    .key_code_c (key_code_c)
  );

  assign paddle_pos = pos_q;

  // Held flags follow make/break strobes for each player's bound keys
  always_comb begin : key_next
    key_held_d = key_held;
    if (make_c || brk_c) begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (key_code_c == UP_KEYS[8*i +: 8]) begin
          key_held_d[2*i] = make_c;
        end
        if (key_code_c == DOWN_KEYS[8*i +: 8]) begin
          key_held_d[2*i+1] = make_c;
        end
      end
    end
  end

  // Motion period counter, 0..COUNT
  always_comb begin : tick_next
    tick_cnt_d = (tick_cnt_q == CNT_LAST) ? '0 : tick_cnt_q + CNT_W'(1);
  end

  // Per-player position, acceleration run length and last direction
  always_comb begin : motion_next
    logic                    up, dn;
    logic [HOLD_W-1:0]       eff;
    logic signed [SUM_W-1:0] cur, step, nxt;

    pos_d  = pos_q;
    hold_d = hold_q;
    dir_d  = dir_q;
    up     = 1'b0;
    dn     = 1'b0;
    eff    = '0;
    cur    = '0;
    step   = '0;
    nxt    = '0;

    for (int i = 0; i < N_PLAYERS; i++) begin
      up   = key_held[2*i];
      dn   = key_held[2*i+1];
      // A run only continues in the direction it started; a reversal restarts it
      eff  = ((hold_q[i] != '0) && (dir_q[i] == dn)) ? hold_q[i] : '0;
      step = (eff < ACCEL_H) ? STEP_S : MAX_STEP_S;
      cur  = signed'({1'b0, pos_q[i]});
      nxt  = dn ? (cur + step) : (cur - step);
      if (dn && (nxt > BOTTOM_S)) begin
        nxt = BOTTOM_S;
      end
      if (!dn && (nxt < FRAME_S)) begin
        nxt = FRAME_S;
      end

      if (center) begin
        pos_d[i]  = START_P;
        hold_d[i] = '0;
      end else if (up == dn) begin
        hold_d[i] = '0;
      end else if (tick && !freeze) begin
        pos_d[i]  = nxt[POS_W-1:0];
        hold_d[i] = (eff == ACCEL_H) ? eff : eff + HOLD_W'(1);
        dir_d[i]  = dn;
      end
    end
  end

  // Output and state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_held   <= '0;
      tick_cnt_q <= '0;
      tick       <= 1'b0;
      pos_q      <= {N_PLAYERS{START_P}};
      hold_q     <= '0;
      dir_q      <= '0;
    end else begin
      key_held   <= key_held_d;
      tick_cnt_q <= tick_cnt_d;
      tick       <= (tick_cnt_d == CNT_LAST);
      pos_q      <= pos_d;
      hold_q     <= hold_d;
      dir_q      <= dir_d;
    end
  end

endmodule
